// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI bus arbiter and its round-robin picker.
package pci_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUSY
  } arb_state_t;

  localparam int NREQ_DEFAULT    = 4;
  localparam int TIMEOUT_DEFAULT = 16;

  // Width of an index that can address n items (never narrower than one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pci_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from (last+1) mod N with
// wrap and reports the first active request, so the previous winner ranks last.
module rr_pick
  import pci_arb_pkg::*;
#(
  parameter int N = NREQ_DEFAULT,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] winner
);

  logic [W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest active request wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = N; i >= 1; i--) begin
      cand = W'((int'(last) + i) % N);
      if (req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin REQ_/GNT_ handshake, bus-idle tracking
// on FRAME_/IRDY_, revocation of unused grants, and transaction statistics.
module pci_bus_arbiter
  import pci_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         REQ_,
  input  logic                    FRAME_,
  input  logic                    IRDY_,
  output logic [NREQ-1:0]         GNT_,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    bus_busy,
  output logic [15:0]             txn_count,
  output logic [7:0]              timeout_count
);

  localparam int OW = idx_width(NREQ);
  localparam int WW = idx_width(TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  arb_state_t      state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [NREQ-1:0] gnt_n_q, gnt_n_d;
  logic            busy_q, busy_d;
  logic [15:0]     txn_q, txn_d;
  logic [7:0]      tout_q, tout_d;

  logic [NREQ-1:0] req_vec;
  logic            bus_idle;
  logic            pick_valid;
  logic [OW-1:0]   pick_winner;

  assign bus_idle = FRAME_ & IRDY_;

  // Convert active-low requests; anything other than a clean 0 counts as idle.
  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_vec[i] = (REQ_[i] === 1'b0);
    end
  end

  rr_pick #(.N(NREQ)) u_rr_pick (
    .req    (req_vec),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Next-state, grant, wait-counter and statistics logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wait_d  = wait_q;
    gnt_n_d = '1;
    txn_d   = txn_q;
    tout_d  = tout_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid && bus_idle) begin
          owner_d = pick_winner;
          last_d  = pick_winner;
          wait_d  = '0;
          gnt_n_d = ~(NREQ'(1) << pick_winner);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!FRAME_) begin
          txn_d   = txn_q + 16'd1;
          state_d = BUSY;
        end else if (!req_vec[owner_q]) begin
          state_d = IDLE;
        end else if (wait_q == WAIT_LAST) begin
          if (tout_q != 8'hFF) begin
            tout_d = tout_q + 8'd1;
          end
          state_d = IDLE;
        end else begin
          wait_d  = wait_q + WW'(1);
          gnt_n_d = ~(NREQ'(1) << owner_q);
        end
      end
      BUSY: begin
        if (bus_idle) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == BUSY);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
      wait_q  <= '0;
      gnt_n_q <= '1;
      busy_q  <= 1'b0;
      txn_q   <= '0;
      tout_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      gnt_n_q <= gnt_n_d;
      busy_q  <= busy_d;
      txn_q   <= txn_d;
      tout_q  <= tout_d;
    end
  end

  assign GNT_          = gnt_n_q;
  assign owner         = owner_q;
  assign bus_busy      = busy_q;
  assign txn_count     = txn_q;
  assign timeout_count = tout_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter (NREQ=4, TIMEOUT=16).
module tb_pci_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  REQ_;
  logic        FRAME_;
  logic        IRDY_;
  logic [3:0]  GNT_;
  logic [1:0]  owner;
  logic        bus_busy;
  logic [15:0] txn_count;
  logic [7:0]  timeout_count;

  int total = 0;
  int bad   = 0;

  pci_bus_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .REQ_          (REQ_),
    .FRAME_        (FRAME_),
    .IRDY_         (IRDY_),
    .GNT_          (GNT_),
    .owner         (owner),
    .bus_busy      (bus_busy),
    .txn_count     (txn_count),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tick until some grant appears, at most 20 cycles.
  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    tick();
    while (GNT_ === 4'hF && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (GNT_ === 4'hF) begin
      bad++;
      $error("FAIL %s: no grant within 20 cycles, GNT_=%0h", tag, GNT_);
    end
  endtask

  // One-data-phase transaction by the current grantee, ending with the bus idle.
  task automatic run_txn(input string tag, input logic [15:0] exp_txn);
    FRAME_ = 1'b0; IRDY_ = 1'b0;
    tick();
    check({tag, "_gnt_off"}, GNT_, 4'hF);
    check({tag, "_busy"}, bus_busy, 1'b1);
    check({tag, "_txn"}, txn_count, exp_txn);
    FRAME_ = 1'b1;
    tick();
    IRDY_ = 1'b1;
    tick();
    check({tag, "_idle"}, bus_busy, 1'b0);
  endtask

  initial begin
    int low_cycles;

    // Reset state
    reset = 1'b1; REQ_ = 4'hF; FRAME_ = 1'b1; IRDY_ = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_gnt", GNT_, 4'hF);
    check("rst_owner", owner, 2'd0);
    check("rst_busy", bus_busy, 1'b0);
    check("rst_txn", txn_count, 16'd0);
    check("rst_tout", timeout_count, 8'd0);

    // Single requester: master 0
    REQ_ = 4'b1110;
    tick();
    check("single_gnt", GNT_, 4'b1110);
    check("single_owner", owner, 2'd0);
    FRAME_ = 1'b0; IRDY_ = 1'b0;
    tick();
    REQ_ = 4'hF;
    check("single_txn", txn_count, 16'd1);
    check("single_gnt_off", GNT_, 4'hF);
    check("single_busy", bus_busy, 1'b1);
    FRAME_ = 1'b1;
    tick();
    check("single_busy_irdy", bus_busy, 1'b1);
    IRDY_ = 1'b1;
    tick();
    check("single_idle", bus_busy, 1'b0);

    // Round-robin from a fresh reset: expect 0,1,2,3,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_rst_txn", txn_count, 16'd0);
    REQ_ = 4'b0000;
    wait_grant("rr0");
    check("rr0_gnt", GNT_, 4'b1110);
    run_txn("rr0", 16'd1);
    wait_grant("rr1");
    check("rr1_gnt", GNT_, 4'b1101);
    run_txn("rr1", 16'd2);
    wait_grant("rr2");
    check("rr2_gnt", GNT_, 4'b1011);
    run_txn("rr2", 16'd3);
    wait_grant("rr3");
    check("rr3_gnt", GNT_, 4'b0111);
    run_txn("rr3", 16'd4);
    wait_grant("rr4");
    check("rr4_gnt", GNT_, 4'b1110);
    run_txn("rr4", 16'd5);

    // Timeout: master 2 never drives FRAME_
    REQ_ = 4'b1011;
    wait_grant("to");
    check("to_gnt", GNT_, 4'b1011);
    low_cycles = 0;
    while (GNT_[2] === 1'b0 && low_cycles < 40) begin
      low_cycles++;
      tick();
    end
    check("to_len", low_cycles, 16);
    check("to_gnt_off", GNT_, 4'hF);
    check("to_count", timeout_count, 8'd1);
    check("to_txn", txn_count, 16'd5);
    // Masters 0 and 2 request: 0 comes before 2 in rotation after 2
    REQ_ = 4'b1010;
    tick();
    check("to_next0", GNT_, 4'b1110);
    REQ_ = 4'b1011;
    tick();
    check("to_next0_off", GNT_, 4'hF);
    tick();
    check("to_next2", GNT_, 4'b1011);
    REQ_ = 4'hF;
    tick();
    check("to_next2_off", GNT_, 4'hF);

    // Request withdrawal by master 1
    REQ_ = 4'b1101;
    wait_grant("wd");
    check("wd_gnt", GNT_, 4'b1101);
    REQ_ = 4'hF;
    tick();
    check("wd_gnt_off", GNT_, 4'hF);
    check("wd_busy", bus_busy, 1'b0);
    check("wd_txn", txn_count, 16'd5);
    REQ_ = 4'b1110;
    tick();
    check("wd_idle_regrant", GNT_, 4'b1110);
    REQ_ = 4'hF;
    tick();
    check("wd_regrant_off", GNT_, 4'hF);

    // Busy bus: leftover transaction holds off master 3
    FRAME_ = 1'b0; IRDY_ = 1'b0;
    REQ_ = 4'b0111;
    tick();
    check("busy_hold0", GNT_, 4'hF);
    tick();
    check("busy_hold1", GNT_, 4'hF);
    FRAME_ = 1'b1;
    tick();
    check("busy_hold2", GNT_, 4'hF);
    IRDY_ = 1'b1;
    tick();
    check("busy_gnt3", GNT_, 4'b0111);
    check("busy_owner", owner, 2'd3);

    // Reset in the middle of a transaction
    FRAME_ = 1'b0; IRDY_ = 1'b0;
    tick();
    check("mid_txn", txn_count, 16'd6);
    check("mid_busy", bus_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_gnt", GNT_, 4'hF);
    check("mid_rst_txn", txn_count, 16'd0);
    check("mid_rst_tout", timeout_count, 8'd0);
    check("mid_rst_busy", bus_busy, 1'b0);
    check("mid_rst_owner", owner, 2'd0);
    FRAME_ = 1'b1; IRDY_ = 1'b1;
    REQ_ = 4'b0000;
    tick();
    check("mid_rst_gnt0", GNT_, 4'b1110);
    REQ_ = 4'hF;
    tick();

    // Timeout counter saturation: 17 cycles per timeout, run 260+ of them
    REQ_ = 4'b1110;
    for (int i = 0; i < 4500; i++) begin
      tick();
    end
    check("sat_tout", timeout_count, 8'd255);
    check("sat_txn", txn_count, 16'd0);
    REQ_ = 4'hF;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
